// File: rtl/regfile_scoreboard_if.sv
// Register-file bus: decode read ports, writeback write port and the
// issue-stage pending-write scoreboard controls.
interface regfile_scoreboard_if #(
   parameter int DATA_W = 32
);
   logic [4:0]        read_addr1;
   logic [4:0]        read_addr2;
   logic [DATA_W-1:0] read_data1;
   logic [DATA_W-1:0] read_data2;
   logic              read_busy1;
   logic              read_busy2;
   logic              write_en;
   logic [4:0]        write_dest;
   logic [DATA_W-1:0] write_data;
   logic              write_retire;
   logic              pend_set_en;
   logic [4:0]        pend_set_dest;
   logic              pend_flush;
   logic              pend_full;

   // Pipeline side: drives addresses, writes and scoreboard updates.
   modport master (
      output read_addr1, read_addr2, write_en, write_dest, write_data,
             write_retire, pend_set_en, pend_set_dest, pend_flush,
      input  read_data1, read_data2, read_busy1, read_busy2, pend_full
   );

   // Register-file side.
   modport slave (
      input  read_addr1, read_addr2, write_en, write_dest, write_data,
             write_retire, pend_set_en, pend_set_dest, pend_flush,
      output read_data1, read_data2, read_busy1, read_busy2, pend_full
   );
endinterface

// File: rtl/regfile_scoreboard.sv
// 32-entry register file with write-to-read bypass and a per-register
// outstanding-producer counter used by decode to stall on pending results.
module regfile_scoreboard #(
   parameter int DATA_W = 32,
   parameter int PEND_W = 2
) (
   input logic                 clk,
   input logic                 rst,
   regfile_scoreboard_if.slave bus
);

   localparam logic [PEND_W-1:0] cnt_max = '1;
   localparam logic [PEND_W-1:0] cnt_one = PEND_W'(1);

   logic [DATA_W-1:0] mem [32];
   logic [PEND_W-1:0] cnt [32];

   logic        ret_hit;
   logic        set_hit;
   logic [31:0] set_sel;
   logic [31:0] ret_sel;

   // Qualify write/retire and set strobes; r0 never participates.
   // NOTE: every signal assigned in always_comb gets a default first, otherwise a latch is inferred.
   always_comb begin
      ret_hit = bus.write_en && bus.write_retire && (bus.write_dest != 5'd0);
      set_hit = bus.pend_set_en && (bus.pend_set_dest != 5'd0);
      set_sel = '0;
      ret_sel = '0;
      for (int i = 1; i < 32; i++) begin
         set_sel[i] = set_hit && (bus.pend_set_dest == 5'(i));
         ret_sel[i] = ret_hit && (bus.write_dest == 5'(i));
      end
   end

   // Read ports: r0 is hard zero, a same-cycle write to the address is bypassed.
   always_comb begin
      if (bus.read_addr1 == 5'd0)
         bus.read_data1 = '0;
      else if (bus.write_en && (bus.write_dest == bus.read_addr1))
         bus.read_data1 = bus.write_data;
      else
         bus.read_data1 = mem[bus.read_addr1];

      if (bus.read_addr2 == 5'd0)
         bus.read_data2 = '0;
      else if (bus.write_en && (bus.write_dest == bus.read_addr2))
         bus.read_data2 = bus.write_data;
      else
         bus.read_data2 = mem[bus.read_addr2];
   end

   // Busy flags and issue back-pressure; a final retire this cycle frees the register now.
   always_comb begin
      bus.read_busy1 = (cnt[bus.read_addr1] != '0) &&
                       !(ret_hit && (bus.write_dest == bus.read_addr1) &&
                         (cnt[bus.read_addr1] == cnt_one));
      bus.read_busy2 = (cnt[bus.read_addr2] != '0) &&
                       !(ret_hit && (bus.write_dest == bus.read_addr2) &&
                         (cnt[bus.read_addr2] == cnt_one));
      bus.pend_full  = (cnt[bus.pend_set_dest] == cnt_max) &&
                       (bus.pend_set_dest != 5'd0);
   end

   // Register storage: writes to r0 are discarded.
   // NOTE: the register array is reset because software expects every register to read 0 after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) mem[i] <= '0;
      end else if (bus.write_en && (bus.write_dest != 5'd0)) begin
         // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
         mem[bus.write_dest] <= bus.write_data;
      end
   end

   // Pending counters: flush wins, set+retire on one register cancels, saturate and floor at zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) cnt[i] <= '0;
      end else if (bus.pend_flush) begin
         for (int i = 0; i < 32; i++) cnt[i] <= '0;
      end else begin
         for (int i = 1; i < 32; i++) begin
            if (set_sel[i] && ret_sel[i] && (cnt[i] != '0))
               cnt[i] <= cnt[i];
            else if (set_sel[i] && (cnt[i] != cnt_max))
               cnt[i] <= cnt[i] + cnt_one;
            else if (ret_sel[i] && (cnt[i] != '0))
               cnt[i] <= cnt[i] - cnt_one;
         end
      end
   end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: table of vectors driven one
// per cycle, expected outputs queued at drive time and compared mid-cycle.
module tb_regfile_scoreboard;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   regfile_scoreboard_if #(.DATA_W(32)) bus ();

   regfile_scoreboard #(.DATA_W(32), .PEND_W(2)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      string       name;
      logic        we;
      logic [4:0]  wd;
      logic [31:0] wdata;
      logic        ret;
      logic        ps;
      logic [4:0]  pd;
      logic        fl;
      logic [4:0]  ra1;
      logic [4:0]  ra2;
      logic [31:0] e_rd1;
      logic [31:0] e_rd2;
      logic        e_b1;
      logic        e_b2;
      logic        e_full;
   } vec_t;

   typedef struct {
      string       name;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic        b1;
      logic        b2;
      logic        full;
   } exp_t;

   int   n_checks = 0;
   int   n_errors = 0;
   exp_t sb[$];
   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input string name, input logic we, input logic [4:0] wd,
                               input logic [31:0] wdata, input logic ret, input logic ps,
                               input logic [4:0] pd, input logic fl, input logic [4:0] ra1,
                               input logic [4:0] ra2, input logic [31:0] e_rd1,
                               input logic [31:0] e_rd2, input logic e_b1, input logic e_b2,
                               input logic e_full);
      vec_t v;
      v.name = name; v.we = we; v.wd = wd; v.wdata = wdata; v.ret = ret;
      v.ps = ps; v.pd = pd; v.fl = fl; v.ra1 = ra1; v.ra2 = ra2;
      v.e_rd1 = e_rd1; v.e_rd2 = e_rd2; v.e_b1 = e_b1; v.e_b2 = e_b2; v.e_full = e_full;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      exp_t e;
      bus.write_en      = v.we;
      bus.write_dest    = v.wd;
      bus.write_data    = v.wdata;
      bus.write_retire  = v.ret;
      bus.pend_set_en   = v.ps;
      bus.pend_set_dest = v.pd;
      bus.pend_flush    = v.fl;
      bus.read_addr1    = v.ra1;
      bus.read_addr2    = v.ra2;
      e.name = v.name; e.rd1 = v.e_rd1; e.rd2 = v.e_rd2;
      e.b1 = v.e_b1; e.b2 = v.e_b2; e.full = v.e_full;
      sb.push_back(e);
   endtask

   task automatic compare();
      exp_t e;
      if (sb.size() == 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL scoreboard_empty: got 0 entries expected 1");
         return;
      end
      e = sb.pop_front();
      check($sformatf("%s rd1", e.name), bus.read_data1, e.rd1);
      check($sformatf("%s rd2", e.name), bus.read_data2, e.rd2);
      check($sformatf("%s busy1", e.name), 32'(bus.read_busy1), 32'(e.b1));
      check($sformatf("%s busy2", e.name), 32'(bus.read_busy2), 32'(e.b2));
      check($sformatf("%s full", e.name), 32'(bus.pend_full), 32'(e.full));
   endtask

   task automatic apply(input vec_t v);
      @(posedge clk);
      #1;
      drive(v);
      @(negedge clk);
      compare();
   endtask

   // Watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      //        name            we wd  wdata         rt ps pd fl ra1 ra2 e_rd1         e_rd2         b1 b2 fu
      vecs.push_back(mk("wr_r5_bypass", 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 5, 0, 32'hDEADBEEF, 0, 0, 0, 0));
      vecs.push_back(mk("rd_r5_stored", 0, 0, 0, 0, 0, 0, 0, 5, 0, 32'hDEADBEEF, 0, 0, 0, 0));
      vecs.push_back(mk("wr_r0_discard", 1, 0, 32'h1234, 0, 0, 0, 0, 0, 5, 0, 32'hDEADBEEF, 0, 0, 0));
      vecs.push_back(mk("set_r0", 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk("r0_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk("set_r8_a", 0, 0, 0, 0, 1, 8, 0, 8, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk("set_r8_b", 0, 0, 0, 0, 1, 8, 0, 8, 0, 0, 0, 1, 0, 0));
      vecs.push_back(mk("ret_r8_a", 1, 8, 32'h11111111, 1, 0, 0, 0, 8, 0, 32'h11111111, 0, 1, 0, 0));
      vecs.push_back(mk("r8_busy", 0, 0, 0, 0, 0, 0, 0, 8, 0, 32'h11111111, 0, 1, 0, 0));
      vecs.push_back(mk("ret_r8_b", 1, 8, 32'h22222222, 1, 0, 0, 0, 8, 0, 32'h22222222, 0, 0, 0, 0));
      vecs.push_back(mk("r8_idle", 0, 0, 0, 0, 0, 0, 0, 8, 0, 32'h22222222, 0, 0, 0, 0));
      vecs.push_back(mk("set_r3_a", 0, 0, 0, 0, 1, 3, 0, 0, 3, 0, 0, 0, 0, 0));
      vecs.push_back(mk("set_r3_b", 0, 0, 0, 0, 1, 3, 0, 0, 3, 0, 0, 0, 1, 0));
      vecs.push_back(mk("set_r3_c", 0, 0, 0, 0, 1, 3, 0, 0, 3, 0, 0, 0, 1, 0));
      vecs.push_back(mk("set_r3_drop", 0, 0, 0, 0, 1, 3, 0, 0, 3, 0, 0, 0, 1, 1));
      vecs.push_back(mk("ret_r3_a", 1, 3, 32'hA, 1, 0, 3, 0, 0, 3, 0, 32'hA, 0, 1, 1));
      vecs.push_back(mk("ret_r3_b", 1, 3, 32'hB, 1, 0, 3, 0, 0, 3, 0, 32'hB, 0, 1, 0));
      vecs.push_back(mk("ret_r3_c", 1, 3, 32'hC, 1, 0, 3, 0, 0, 3, 0, 32'hC, 0, 0, 0));
      vecs.push_back(mk("r3_idle", 0, 0, 0, 0, 0, 3, 0, 0, 3, 0, 32'hC, 0, 0, 0));
      vecs.push_back(mk("set_r9_a", 0, 0, 0, 0, 1, 9, 0, 9, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk("set_r9_b", 0, 0, 0, 0, 1, 9, 0, 9, 0, 0, 0, 1, 0, 0));
      vecs.push_back(mk("set_ret_r9", 1, 9, 32'h99, 1, 1, 9, 0, 9, 0, 32'h99, 0, 1, 0, 0));
      vecs.push_back(mk("r9_hold", 0, 0, 0, 0, 0, 0, 0, 9, 0, 32'h99, 0, 1, 0, 0));
      vecs.push_back(mk("ret_r9_a", 1, 9, 32'h98, 1, 0, 0, 0, 9, 0, 32'h98, 0, 1, 0, 0));
      vecs.push_back(mk("ret_r9_b", 1, 9, 32'h97, 1, 0, 0, 0, 9, 0, 32'h97, 0, 0, 0, 0));
      vecs.push_back(mk("set_r9_c", 0, 0, 0, 0, 1, 9, 0, 9, 0, 32'h97, 0, 0, 0, 0));
      vecs.push_back(mk("set_r9_d", 0, 0, 0, 0, 1, 9, 0, 9, 0, 32'h97, 0, 1, 0, 0));
      vecs.push_back(mk("flush_wr_r9", 1, 9, 32'h55, 0, 1, 9, 1, 9, 0, 32'h55, 0, 1, 0, 0));
      vecs.push_back(mk("r9_flushed", 0, 0, 0, 0, 0, 0, 0, 9, 0, 32'h55, 0, 0, 0, 0));
      vecs.push_back(mk("set_r31", 0, 0, 0, 0, 1, 31, 0, 31, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk("alu_wr_r31", 1, 31, 32'h31, 0, 0, 0, 0, 31, 0, 32'h31, 0, 1, 0, 0));
      vecs.push_back(mk("r31_busy", 0, 0, 0, 0, 0, 0, 0, 31, 0, 32'h31, 0, 1, 0, 0));
      vecs.push_back(mk("two_ports", 1, 12, 32'hC0DE, 0, 0, 0, 0, 12, 5, 32'hC0DE, 32'hDEADBEEF, 0, 0, 0));

      // Hold all inputs idle through reset.
      drive(mk("reset_hold", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      compare();
      @(posedge clk);
      #1 rst = 1'b0;

      // After reset every register reads zero and nothing is busy or full.
      for (int i = 0; i < 32; i++) begin
         apply(mk($sformatf("reset_r%0d", i), 0, 0, 0, 0, 0, 5'(i), 0,
                  5'(i), 5'(31 - i), 0, 0, 0, 0, 0));
      end

      foreach (vecs[k]) apply(vecs[k]);

      // Asynchronous reset mid-operation: r31 is busy and holds data.
      @(posedge clk);
      #1;
      drive(mk("pre_rst", 0, 0, 0, 0, 0, 0, 0, 31, 12, 32'h31, 32'hC0DE, 1, 0, 0));
      #2;
      compare();
      rst = 1'b1;
      #1;
      check("async_rst rd1", bus.read_data1, 32'h0);
      check("async_rst rd2", bus.read_data2, 32'h0);
      check("async_rst busy1", 32'(bus.read_busy1), 32'h0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("post_rst rd1", bus.read_data1, 32'h0);
      check("post_rst busy1", 32'(bus.read_busy1), 32'h0);

      if (sb.size() != 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- 32 x 32-bit general-purpose register file: the receiving end of the writeback stage's register-write interface (write enable, 5-bit destination, 32-bit data).
- Provides two combinational read ports for decode, with same-cycle write-to-read bypass.
- Holds a per-register pending-write scoreboard. Issue marks a destination as pending when a long-latency producer (load, mul/div) is dispatched; the matching writeback retires it. Decode uses the busy flags to stall.

Parameters:
- DATA_W, 32, register width.
- PEND_W, 2, width of each per-register outstanding-producer counter (max 2^PEND_W-1 in flight per register).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  asynchronous active-high reset.
- read_addr1  input  5  read port 1 register index.
- read_addr2  input  5  read port 2 register index.
- read_data1  output  DATA_W  read port 1 data (combinational).
- read_data2  output  DATA_W  read port 2 data (combinational).
- read_busy1  output  1  register at read_addr1 has an outstanding producer.
- read_busy2  output  1  register at read_addr2 has an outstanding producer.
- write_en  input  1  register write strobe from writeback.
- write_dest  input  5  write destination index.
- write_data  input  DATA_W  write data.
- write_retire  input  1  this write completes a scoreboarded producer; qualified by write_en.
- pend_set_en  input  1  issue stage marks a new outstanding producer.
- pend_set_dest  input  5  destination being marked.
- pend_flush  input  1  clear all pending counters (pipeline flush/exception).
- pend_full  output  1  counter at pend_set_dest is saturated; issue must stall.

Behaviour:
- Reset (async, rst=1): all 32 registers set to 0; all pending counters set to 0. Reads then return 0, busy flags 0, pend_full 0.
- Register 0: always reads 0. Writes to index 0 are discarded. Its counter never increments. read_busy for index 0 is always 0.
- Write: on a rising edge with write_en=1 and write_dest!=0, mem[write_dest] <= write_data. One-cycle write latency.
- Read: read_data = mem[read_addr] combinationally.
- Bypass: if write_en=1, write_dest==read_addr and read_addr!=0 in the same cycle, read_data=write_data. Each port is bypassed independently.
- Counter increment: when pend_set_en=1, pend_set_dest!=0 and the counter is not saturated, cnt[pend_set_dest] +1 at the edge.
- Counter decrement: when write_en=1, write_retire=1, write_dest!=0 and cnt>0, cnt[write_dest] -1 at the edge. A retire with cnt==0 is ignored; counters never underflow.
- Simultaneous set and retire on the same register: net counter change 0. Saturation does not block this case.
- Saturation: pend_full = (cnt[pend_set_dest] == all-ones) && pend_set_dest!=0. A set while pend_full=1 and no same-register retire is dropped; the counter is unchanged.
- read_busy: (cnt[read_addr] != 0), with one exception. If a retire to the same index occurs this cycle and cnt==1, read_busy=0, so the bypassed data is consumable immediately.
- A pend_set in the same cycle does not raise read_busy until the next cycle.
- pend_flush: all counters go to 0 at the edge and override set/retire in that cycle. Register contents are unaffected, and the same-cycle write still commits.
- Writes with write_retire=0 (ALU results, link writes to r31) update data only and never touch counters.
- Reset asserted mid-operation clears everything immediately; there is no partial-write hazard beyond the asynchronous clear.

Test Plan:
- Reset, then read all 32 indices -> every read_data 0, every read_busy 0, pend_full 0.
- Write r5=0xDEADBEEF, with read_addr1=5 in the same cycle -> read_data1=0xDEADBEEF (bypass) that cycle; next cycle read_data1=0xDEADBEEF from storage.
- write_en=1, write_dest=0, write_data=0x1234 -> read r0 stays 0. pend_set on r0 -> read_busy stays 0.
- pend_set r8 twice, then retire r8 once -> read_busy=1. Retire again with read_addr1=8 -> read_busy1=0 in that retire cycle and read_data1=write_data.
- pend_set r3 three times -> pend_full=1 with pend_set_dest=3. Fourth set dropped. Three retires -> busy clears exactly on the third.
- Counter at 2, then simultaneous pend_set and retire on r9 -> counter stays 2. pend_flush with r9 busy -> read_busy 0 next cycle, and data written in the flush cycle persists.
